// File: rtl/riscv_if_fetch_unit.sv
// Stage-1 instruction fetch: owns the PC, issues credit-limited I-cache requests,
// queues in-order responses and presents {pc, inst} to ID; redirect flushes everything.
module riscv_if_fetch_unit #(
    parameter int          XLEN      = 64,
    parameter int          FQ_DEPTH  = 4,
    parameter logic [63:0] RESET_VEC = 64'h0000_0000_8000_0000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic                          icache_req_valid,
    input  logic                          icache_req_ready,
    output logic [XLEN-1:0]               icache_req_addr,
    input  logic                          icache_rsp_valid,
    input  logic [31:0]                   icache_rsp_inst,
    output logic                          if_valid,
    output logic [XLEN-1:0]               if_pc,
    output logic [31:0]                   if_inst,
    input  logic                          id_ready,
    output logic [$clog2(FQ_DEPTH+1)-1:0] fq_count
);

    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int PW = $clog2(FQ_DEPTH);
    localparam logic [XLEN-1:0] RESET_PC = {RESET_VEC[XLEN-1:2], 2'b00};
    localparam logic [CW:0]     CREDIT   = (CW + 1)'(FQ_DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } fq_entry_t;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   count;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    fq_entry_t       mem [FQ_DEPTH];

    logic [CW:0]     in_use;
    logic [XLEN-1:0] redirect_tgt;
    logic            req_fire;
    logic            push;
    logic            pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FQ_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Requests in flight plus queued entries never exceed the queue size, so
    // every response has a slot waiting for it.
    assign in_use           = {1'b0, outstanding} + {1'b0, count};
    assign icache_req_valid = rst_n && !redirect_valid && (in_use < CREDIT);
    assign icache_req_addr  = pc;
    assign redirect_tgt     = redirect_pc & ~XLEN'(3);

    assign req_fire = icache_req_valid && icache_req_ready;
    assign push     = icache_rsp_valid && !redirect_valid && (drop == '0);
    assign pop      = if_valid && id_ready;

    assign if_valid = (count != '0) && !redirect_valid;
    assign if_pc    = mem[head].pc;
    assign if_inst  = mem[head].inst;
    assign fq_count = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight belongs to the old path and must be dropped.
            pc          <= redirect_tgt;
            rsp_pc      <= redirect_tgt;
            outstanding <= outstanding - CW'(icache_rsp_valid);
            drop        <= outstanding - CW'(icache_rsp_valid);
            count       <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            if (req_fire) pc <= pc + XLEN'(4);
            if (icache_rsp_valid && drop != '0) drop <= drop - CW'(1);
            if (push) begin
                tail   <= next_ptr(tail);
                rsp_pc <= rsp_pc + XLEN'(4);
            end
            if (pop) head <= next_ptr(head);

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            case ({req_fire, icache_rsp_valid})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // NOTE: queue storage has no reset; head/tail/count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= '{pc: rsp_pc, inst: icache_rsp_inst};
    end

    a_rsp_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        icache_rsp_valid |-> (outstanding != '0));
    a_fq_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        count <= CW'(FQ_DEPTH));
    a_addr_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        icache_req_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_riscv_if_fetch_unit.sv
// Random-stimulus bench for riscv_if_fetch_unit against a queue-based reference model,
// plus a 32-bit instance exercising PC wrap-around.
module tb_riscv_if_fetch_unit;

    localparam int          D        = 4;
    localparam logic [63:0] RST_VEC  = 64'h0000_0000_8000_0000;
    localparam logic [31:0] RST_VEC32 = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        redirect_valid, req_ready, rsp_valid, id_ready;
    logic [63:0] redirect_pc;
    logic [31:0] rsp_inst;
    logic        req_valid, if_valid;
    logic [63:0] req_addr, if_pc;
    logic [31:0] if_inst;
    logic [2:0]  fq_count;

    logic        redirect_valid_w, req_ready_w, rsp_valid_w, id_ready_w;
    logic [31:0] redirect_pc_w, rsp_inst_w;
    logic        req_valid_w, if_valid_w;
    logic [31:0] req_addr_w, if_pc_w, if_inst_w;
    logic [2:0]  fq_count_w;

    riscv_if_fetch_unit u_dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .icache_req_valid(req_valid), .icache_req_ready(req_ready), .icache_req_addr(req_addr),
        .icache_rsp_valid(rsp_valid), .icache_rsp_inst(rsp_inst),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .id_ready(id_ready), .fq_count(fq_count)
    );

    riscv_if_fetch_unit #(.XLEN(32), .FQ_DEPTH(4), .RESET_VEC(64'hFFFF_FFF8)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w),
        .icache_req_valid(req_valid_w), .icache_req_ready(req_ready_w), .icache_req_addr(req_addr_w),
        .icache_rsp_valid(rsp_valid_w), .icache_rsp_inst(rsp_inst_w),
        .if_valid(if_valid_w), .if_pc(if_pc_w), .if_inst(if_inst_w),
        .id_ready(id_ready_w), .fq_count(fq_count_w)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: architectural view of the fetch unit plus an in-order cache.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        logic [31:0] inst;
        int          due;
    } creq_t;

    logic [63:0] m_pc, m_rsp_pc;
    int          m_out, m_drop, cyc;
    ent_t        m_q[$];
    creq_t       cq[$];

    int p_ready, p_id, p_redir, p_rsp, lat_max;
    logic exp_rv, exp_iv;

    task automatic model_reset();
        m_pc     = RST_VEC;
        m_rsp_pc = RST_VEC;
        m_out    = 0;
        m_drop   = 0;
        m_q.delete();
        cq.delete();
    endtask

    task automatic set_mode(input int rdy, input int idr, input int rdr, input int rsp, input int lat);
        p_ready = rdy; p_id = idr; p_redir = rdr; p_rsp = rsp; lat_max = lat;
    endtask

    task automatic step_drive();
        @(negedge clk);
        redirect_valid = ($urandom_range(99) < p_redir);
        redirect_pc    = {$urandom, $urandom};
        req_ready      = ($urandom_range(99) < p_ready);
        id_ready       = ($urandom_range(99) < p_id);
        rsp_valid      = (cq.size() != 0) && (cq[0].due <= cyc) && ($urandom_range(99) < p_rsp);
        rsp_inst       = rsp_valid ? cq[0].inst : $urandom;
        #1;
        exp_rv = !redirect_valid && (m_out + m_q.size() < D);
        exp_iv = (m_q.size() != 0) && !redirect_valid;
    endtask

    task automatic step_eval();
        logic fire, pop;
        logic [63:0] tgt;
        check("req_valid", req_valid, exp_rv);
        check("if_valid", if_valid, exp_iv);
        check("fq_count", fq_count, m_q.size());
        if (exp_rv) check("req_addr", req_addr, m_pc);
        if (exp_iv) begin
            check("if_pc", if_pc, m_q[0].pc);
            check("if_inst", if_inst, m_q[0].inst);
        end

        fire = exp_rv && req_ready;
        pop  = exp_iv && id_ready;
        if (rsp_valid) void'(cq.pop_front());
        if (redirect_valid) begin
            tgt      = redirect_pc & ~64'h3;
            m_pc     = tgt;
            m_rsp_pc = tgt;
            m_q.delete();
            m_out    = m_out - int'(rsp_valid);
            m_drop   = m_out;
        end else begin
            if (fire) begin
                cq.push_back('{inst: $urandom, due: cyc + int'($urandom_range(lat_max, 1))});
                m_pc  = m_pc + 64'd4;
                m_out = m_out + 1;
            end
            if (pop) void'(m_q.pop_front());
            if (rsp_valid) begin
                m_out = m_out - 1;
                if (m_drop > 0) m_drop = m_drop - 1;
                else begin
                    m_q.push_back('{pc: m_rsp_pc, inst: rsp_inst});
                    m_rsp_pc = m_rsp_pc + 64'd4;
                end
            end
        end
        cyc++;
    endtask

    task automatic step();
        step_drive();
        step_eval();
    endtask

    task automatic idle_inputs();
        redirect_valid = 1'b0; redirect_pc = '0; req_ready = 1'b0;
        rsp_valid = 1'b0; rsp_inst = '0; id_ready = 1'b0;
    endtask

    initial begin
        int   tries;
        int   nf, np;
        logic fired_prev;
        logic [31:0] exp_inst[$];
        logic [31:0] a32;

        rst_n = 1'b0;
        cyc   = 0;
        idle_inputs();
        redirect_valid_w = 1'b0; redirect_pc_w = '0; req_ready_w = 1'b0;
        rsp_valid_w = 1'b0; rsp_inst_w = '0; id_ready_w = 1'b0;
        model_reset();

        #12;
        check("rst_req_valid", req_valid, 1'b0);
        check("rst_if_valid", if_valid, 1'b0);
        check("rst_fq_count", fq_count, 0);
        #11 rst_n = 1'b1;

        // Streaming: always ready, single-cycle latency
        set_mode(100, 100, 0, 100, 1);
        repeat (30) step();

        // ID stalled: credit fills the queue and requests stop
        set_mode(100, 0, 0, 100, 1);
        repeat (12) step();
        step_drive();
        check("stall_fq_full", fq_count, D);
        check("stall_req_off", req_valid, 1'b0);
        step_eval();
        set_mode(100, 100, 0, 100, 1);
        repeat (12) step();

        // Long latency with redirects landing on in-flight requests
        set_mode(100, 100, 15, 100, 3);
        repeat (200) step();

        // Fully random mix
        set_mode(70, 60, 8, 60, 4);
        repeat (1500) step();

        // Async reset with three entries queued
        set_mode(100, 0, 0, 100, 1);
        tries = 0;
        while (m_q.size() != 3 && tries < 60) begin
            step();
            tries++;
        end
        check("reach_fq3", m_q.size(), 3);
        @(negedge clk);
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_if_valid", if_valid, 1'b0);
        check("async_rst_req_valid", req_valid, 1'b0);
        check("async_rst_fq_count", fq_count, 0);
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        set_mode(100, 100, 0, 100, 1);
        step_drive();
        check("post_rst_addr", req_addr, RST_VEC);
        step_eval();
        repeat (20) step();

        // 32-bit instance: PC wraps from FFFF_FFF8 through zero
        @(negedge clk);
        idle_inputs();
        nf = 0;
        np = 0;
        fired_prev = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            rsp_valid_w = fired_prev;
            rsp_inst_w  = fired_prev ? exp_inst[nf-1] : 32'h0;
            req_ready_w = 1'b1;
            id_ready_w  = 1'b1;
            #1;
            check("w_req_valid", req_valid_w, 1'b1);
            a32 = RST_VEC32 + 32'(4 * nf);
            check("w_req_addr", req_addr_w, a32);
            check("w_if_valid", if_valid_w, k >= 2);
            if (if_valid_w) begin
                a32 = RST_VEC32 + 32'(4 * np);
                check("w_if_pc", if_pc_w, a32);
                check("w_if_inst", if_inst_w, exp_inst[np]);
                np++;
            end
            exp_inst.push_back($urandom);
            nf++;
            fired_prev = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
